alu_result_deserializer: RTL
============================

Name: alu_result_deserializer

Overview:
- Downstream consumer of the serial ALU's single-bit result stream (alu Data_out).
- Detects framed serial results, checks parity and stop bit, and assembles each result into a parallel word.
- Presents the word to the parallel side through a valid/ack hold register.
- Flags parity errors, framing errors and overruns.

Parameters:
- WIDTH, 8, number of result data bits per frame.
- PARITY_EN, 1, 1 = frame carries an even-parity bit after the data bits; 0 = no parity bit.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Data_in  input  1  serial result stream from alu Data_out; sampled once per rising edge.
- Result_ack  input  1  consumer acknowledges the held Result.
- Result  output  WIDTH  last accepted result word.
- Result_valid  output  1  Result holds an unacknowledged word.
- Parity_error  output  1  parity status of the word in Result; updated together with Result.
- Framing_error  output  1  one-cycle pulse: bad stop bit, frame discarded.
- Overrun  output  1  sticky: a good frame was dropped because Result was still pending.
- Busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - FSM goes to IDLE; bit counter and shift register clear.
  - Every output is 0.
  - Reset mid-frame discards the partial frame. After release, the receiver hunts for a new start bit.
- Frame format, one bit per clock:
  - Idle line is 0; start bit is 1.
  - WIDTH data bits follow, LSB first.
  - If PARITY_EN=1, an even-parity bit follows: the data ones plus the parity bit total an even count.
  - Stop bit is 0.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: Data_in=1 -> DATA, counter=0. Otherwise stay.
  - DATA: shift Data_in into bit position counter and increment the counter. After the WIDTH-th bit -> PARITY if PARITY_EN=1, else -> STOP.
  - PARITY: compute perr = Data_in XOR (reduction XOR of data bits) -> STOP.
  - STOP: always -> IDLE on the next cycle (see stop-bit checks below).
- Stop-bit checks:
  - Data_in=0 (good frame): commit the frame.
  - Data_in=1 (bad frame): pulse Framing_error for one cycle and discard the frame. Result, Result_valid and Parity_error are unchanged. This 1 is NOT taken as a new start bit.
- Commit rules:
  - Commit loads Result <= shift register and Parity_error <= perr (0 when PARITY_EN=0), and sets Result_valid <= 1.
  - If Result_valid=1 and Result_ack=0 in the commit cycle: drop the new frame, keep the old Result and Parity_error, set Overrun <= 1.
  - If Result_valid=1 and Result_ack=1 in the same cycle: accept the new frame, Result_valid stays 1, no overrun.
- Latency: the start bit is sampled at edge E0 and the stop bit at edge E(WIDTH+1+PARITY_EN). Result_valid is visible immediately after that edge (WIDTH=8, parity on: E10).
- Back-to-back frames: a start bit on the cycle right after STOP is accepted. Minimum frame period is WIDTH+2+PARITY_EN cycles.
- Ack handshake:
  - Result_ack=1 while Result_valid=1 clears Result_valid at the next edge, unless a commit happens in that same cycle.
  - Result keeps its value after ack.
  - Ack with Result_valid=0 is ignored.
- Overrun:
  - Sticky; cleared only by reset or by an ack cycle (Result_ack=1 and Result_valid=1).
  - If an overrun-causing commit coincides with an ack, no overrun occurs (the commit is accepted).
- Busy = (state != IDLE); purely state-derived, no glitch paths.
- Data_in is assumed synchronous to Clock; no internal synchronizer.

Test Plan (WIDTH=8, PARITY_EN=1 unless stated):
- Reset pulse mid-frame (after 4 data bits), then a full frame for 0x3C -> all outputs 0 during and after reset. Result=0x3C, Result_valid=1 after the stop edge; no error flags.
- Stream 1, bits of 0xA5 LSB-first (1,0,1,0,0,1,0,1), parity 0, stop 0 -> Result=0xA5, Result_valid=1 exactly 10 edges after the start edge, Parity_error=0. Then ack -> Result_valid=0 next edge, Result still 0xA5.
- Frame 0x01 with parity 0 (wrong) -> Result=0x01, Result_valid=1, Parity_error=1.
- Frame 0x0F with stop bit 1 -> Framing_error high exactly one cycle, Result/Result_valid unchanged. FSM in IDLE, and the next cycle does not start a frame.
- Two back-to-back good frames 0x11 then 0x22, no ack -> Result=0x11, Overrun=1. Repeat with ack asserted in the second frame's stop cycle -> Result=0x22, Result_valid=1, Overrun=0.
- PARITY_EN=0, frame 1, bits of 0x80, stop 0 -> Result=0x80 after 9 edges from start, Parity_error=0. Busy high from the edge after start through the stop edge.

Source files
------------

// File: rtl/alu_result_deserializer.sv
// Assembles framed serial ALU results (start=1, LSB-first data, optional even parity, stop=0) into a held word.
// Result_valid rises on the stop-bit edge; a good frame arriving while the held word is unacknowledged is dropped (Overrun).
module alu_result_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Data_in,
  input  logic             Result_ack,
  output logic [WIDTH-1:0] Result,
  output logic             Result_valid,
  output logic             Parity_error,
  output logic             Framing_error,
  output logic             Overrun,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             perr;
  logic             last_bit;
  logic             commit;
  logic             accept;
  logic             ack_cycle;

  assign last_bit  = (bit_cnt == CW'(WIDTH - 1));
  assign commit    = (state == STOP) && !Data_in;
  assign accept    = commit && (!Result_valid || Result_ack);
  assign ack_cycle = Result_ack && Result_valid;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (Data_in) state_nxt = DATA;
      DATA:    if (last_bit) state_nxt = PARITY_EN ? PARITY : STOP;
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != IDLE);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      bit_cnt       <= '0;
      shreg         <= '0;
      perr          <= 1'b0;
      Result        <= '0;
      Result_valid  <= 1'b0;
      Parity_error  <= 1'b0;
      Framing_error <= 1'b0;
      Overrun       <= 1'b0;
    end else begin
      case (state)
        IDLE:   if (Data_in) bit_cnt <= '0;
        // Right shift lands the first (LSB) bit in position 0 after WIDTH bits.
        DATA: begin
          shreg   <= {Data_in, shreg[WIDTH-1:1]};
          bit_cnt <= bit_cnt + CW'(1);
        end
        PARITY: perr <= Data_in ^ (^shreg);
        default: ;
      endcase

      Framing_error <= (state == STOP) && Data_in;

      if (accept) begin
        Result       <= shreg;
        Parity_error <= PARITY_EN ? perr : 1'b0;
        Result_valid <= 1'b1;
      end else if (ack_cycle) begin
        Result_valid <= 1'b0;
      end

      // An ack in the commit cycle makes room, so it never coincides with a drop.
      if (ack_cycle)                  Overrun <= 1'b0;
      else if (commit && Result_valid) Overrun <= 1'b1;
    end
  end

endmodule
